branch_resolve: RTL
===================

// Module: branch_resolve
// PURPOSE
//  EX-stage consumer of the comparator flags. Resolves MIPS conditional branches/jumps, checks them against the
//  fetch-time prediction from an internal 2-bit BHT, and issues a registered redirect/flush to fetch.
//  One-entry output buffer with valid/ready handshakes on both sides. Also counts mispredictions.
// PARAMETERS
//  WIDTH        32  PC/target width in bits
//  BHT_ENTRIES  16  number of 2-bit counters; power of 2, >=2
//  IDX_W        $clog2(BHT_ENTRIES)  BHT index width (derived, do not override)
// PORTS
//  clk            in   1      rising-edge clock, single clock domain
//  rst_n          in   1      synchronous, active-low reset
//  q_pc           in   WIDTH  fetch lookup PC
//  q_taken        out  1      prediction for q_pc = bht[q_pc[IDX_W+1:2]][1] (combinational read)
//  in_valid       in   1      EX presents a resolvable instruction
//  in_ready       out  1      = !out_valid || out_ready
//  br_type        in   3      0 NONE,1 BEQ,2 BNE,3 BLEZ,4 BGTZ,5 BLTZ,6 BGEZ,7 J
//  eq,neq         in   1 ea   rs==rt / rs!=rt flags from the comparator stage
//  slt,slte       in   1 ea   signed rs<0 / rs<=0 (rt side tied to zero)
//  sgt,sgte       in   1 ea   signed rs>0 / rs>=0
//  pc             in   WIDTH  PC of the branch
//  target         in   WIDTH  branch/jump target
//  pred_taken     in   1      prediction fetch used for this instruction
//  out_valid      out  1      result buffer full
//  out_ready      in   1      downstream accepts the result
//  res_taken      out  1      resolved direction
//  res_mispredict out  1      res_taken != pred_taken
//  res_pc         out  WIDTH  correct next PC: taken ? target : pc+4
//  flush          out  1      = out_valid && out_ready && res_mispredict
//  miss_count     out  16     saturating count of transferred mispredictions
// BEHAVIOUR
//  - Accept = in_valid && in_ready. Latency 1: results are registered at the accept edge, out_valid=1 next cycle.
//  - Buffer: out_valid set on accept; cleared on out_valid&&out_ready with no new accept. Back-to-back accept+drain
//    in the same cycle keeps out_valid=1 with the new data (full throughput). Output data is held stable while
//    out_valid && !out_ready.
//  - Direction: BEQ=eq, BNE=neq, BLEZ=slte, BGTZ=sgt, BLTZ=slt, BGEZ=sgte, J=1, NONE=0.
//  - res_pc = taken ? target : pc+32'd4, truncated to WIDTH (wraps modulo 2^WIDTH; 0xFFFF_FFFC+4 -> 0).
//  - BHT: counters 0..3, MSB = predict taken. Updated on accept for types 1-6 only: taken -> +1 saturating at 3;
//    not taken -> -1 saturating at 0. NONE and J never update. Index = pc[IDX_W+1:2].
//  - q_taken reads pre-edge state. There is no write-through bypass: a same-cycle update is visible from the next cycle.
//  - miss_count increments on each flush cycle and saturates at 16'hFFFF.
//  - Reset (rst_n=0 at a clk edge, including mid-operation):
//      out_valid=0, res_taken=0, res_mispredict=0, res_pc=0, miss_count=0, every BHT counter=2'b01.
//      Any buffered result is discarded and flush=0. in_ready=1 from the first cycle after reset.
//  - Illegal states: none. The 3-bit br_type is fully decoded.
// TESTING
//  1 Reset, then q_pc=0x40 -> q_taken=0. BEQ eq=1 pc=0x40 tgt=0x80 pred=0 -> next cycle out_valid=1,
//    res_taken=1, res_pc=0x80, mispredict=1; flush=1 with out_ready=1; miss_count=1.
//  2 Same BEQ taken twice more -> q_taken(0x40)=1 after the 1st update, and the counter saturates at 3 after the 2nd.
//    Four not-taken updates -> the counter ends at 0 and does not underflow.
//  3 out_ready=0 for 3 cycles with out_valid=1 -> in_ready=0, output held, new in_valid ignored. Then out_ready=1
//    with in_valid=1 -> same-cycle drain+accept, out_valid stays 1 with the new data.
//  4 BNE neq=0 pc=0xFFFF_FFFC pred=0 -> res_taken=0, res_pc=0x0, mispredict=0, flush=0.
//    J pred=0 -> taken, mispredict=1, BHT unchanged.
//  5 rst_n=0 for one edge while out_valid=1 with mispredict pending -> out_valid=0, flush never asserted,
//    miss_count=0, all q_taken=0.
//  6 Drive 70000 mispredicting transfers -> miss_count=0xFFFF and holds there.

Source files
------------

// File: rtl/branch_resolve.sv
// EX-stage branch resolution: decodes comparator flags into a direction, checks it against the fetch
// prediction, trains a 2-bit BHT and presents a one-entry buffered redirect with a misprediction counter.
module branch_resolve #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned BHT_ENTRIES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  // fetch-side prediction lookup
  input  logic [WIDTH-1:0] q_pc,
  output logic             q_taken,
  // EX-side request
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       br_type,
  input  logic             eq,
  input  logic             neq,
  input  logic             slt,
  input  logic             slte,
  input  logic             sgt,
  input  logic             sgte,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] target,
  input  logic             pred_taken,
  // resolved result towards fetch
  output logic             out_valid,
  input  logic             out_ready,
  output logic             res_taken,
  output logic             res_mispredict,
  output logic [WIDTH-1:0] res_pc,
  output logic             flush,
  output logic [15:0]      miss_count
);

  localparam int unsigned IDX_W   = $clog2(BHT_ENTRIES);
  localparam int unsigned CNT_W   = 2;
  localparam int unsigned MISS_W  = 16;
  localparam logic [CNT_W-1:0]  CNT_RST = 2'b01;
  localparam logic [CNT_W-1:0]  CNT_MAX = 2'b11;
  localparam logic [CNT_W-1:0]  CNT_MIN = 2'b00;
  localparam logic [MISS_W-1:0] MISS_MAX = 16'hFFFF;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BLEZ = 3'd3,
    BR_BGTZ = 3'd4,
    BR_BLTZ = 3'd5,
    BR_BGEZ = 3'd6,
    BR_J    = 3'd7
  } br_type_e;

  logic [CNT_W-1:0]  r_bht [BHT_ENTRIES];
  logic              r_out_valid;
  logic              r_res_taken;
  logic              r_res_mispredict;
  logic [WIDTH-1:0]  r_res_pc;
  logic [MISS_W-1:0] r_miss_count;

  br_type_e          w_type;
  logic              w_accept;
  logic              w_drain;
  logic              w_flush;
  logic              w_taken;
  logic              w_trains;
  logic [WIDTH-1:0]  w_next_pc;
  logic [IDX_W-1:0]  w_upd_idx;
  logic [IDX_W-1:0]  w_q_idx;
  logic [CNT_W-1:0]  w_cnt_cur;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_unused_pc_bits;

  assign w_type    = br_type_e'(br_type);
  assign w_q_idx   = q_pc[IDX_W+1:2];
  assign w_upd_idx = pc[IDX_W+1:2];

  // Only the index bits of the lookup PC matter.
  assign w_unused_pc_bits = ^{q_pc[WIDTH-1:IDX_W+2], q_pc[1:0]};

  // Prediction read sees the table as it stood before this edge's update.
  assign q_taken = r_bht[w_q_idx][CNT_W-1];

  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;
  assign w_drain  = r_out_valid && out_ready;
  assign w_flush  = w_drain && r_res_mispredict;
  assign flush    = w_flush;

  // Direction decode and whether the type trains the BHT.
  always_comb begin
    w_taken  = 1'b0;
    w_trains = 1'b0;
    case (w_type)
      BR_NONE: w_taken = 1'b0;
      BR_BEQ:  begin w_taken = eq;   w_trains = 1'b1; end
      BR_BNE:  begin w_taken = neq;  w_trains = 1'b1; end
      BR_BLEZ: begin w_taken = slte; w_trains = 1'b1; end
      BR_BGTZ: begin w_taken = sgt;  w_trains = 1'b1; end
      BR_BLTZ: begin w_taken = slt;  w_trains = 1'b1; end
      BR_BGEZ: begin w_taken = sgte; w_trains = 1'b1; end
      BR_J:    w_taken = 1'b1;
      default: w_taken = 1'b0;
    endcase
  end

  assign w_next_pc = w_taken ? target : (pc + WIDTH'(4));

  // Saturating 2-bit counter step for the entry being trained.
  always_comb begin
    w_cnt_cur = r_bht[w_upd_idx];
    w_cnt_nxt = w_cnt_cur;
    if (w_taken) begin
      if (w_cnt_cur != CNT_MAX) w_cnt_nxt = w_cnt_cur + CNT_W'(1);
    end else begin
      if (w_cnt_cur != CNT_MIN) w_cnt_nxt = w_cnt_cur - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(BHT_ENTRIES); i++) r_bht[i] <= CNT_RST;
    end else if (w_accept && w_trains) begin
      r_bht[w_upd_idx] <= w_cnt_nxt;
    end
  end

  // One-entry result buffer; payload only moves on accept so it holds under backpressure.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid      <= 1'b0;
      r_res_taken      <= 1'b0;
      r_res_mispredict <= 1'b0;
      r_res_pc         <= '0;
    end else begin
      if (w_accept) begin
        r_out_valid      <= 1'b1;
        r_res_taken      <= w_taken;
        r_res_mispredict <= (w_taken != pred_taken);
        r_res_pc         <= w_next_pc;
      end else if (w_drain) begin
        r_out_valid      <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_miss_count <= '0;
    end else if (w_flush && (r_miss_count != MISS_MAX)) begin
      r_miss_count <= r_miss_count + MISS_W'(1);
    end
  end

  assign out_valid      = r_out_valid;
  assign res_taken      = r_res_taken;
  assign res_mispredict = r_res_mispredict;
  assign res_pc         = r_res_pc;
  assign miss_count     = r_miss_count;

endmodule
